seq_shift_add_multiplier: RTL

Parametrised sequential shift-and-add multiplier with its own controller, start/busy/done handshake, selectable signed or unsigned operation, and early termination once the remaining multiplier bits are zero. It replaces the bare multiplier datapath plus external controller pairing. Upstream logic issues one multiply and gets the 2N-bit product when `done` rises.

---
 rtl/mult_pkg.sv | 10 +
 rtl/mult_datapath.sv | 63 ++++++
 rtl/seq_shift_add_multiplier.sv | 84 ++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types for the sequential shift-and-add multiplier
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage : mult_pkg

// File: rtl/mult_datapath.sv
// rtl/mult_datapath.sv - operand registers, accumulator and product for shift-and-add multiply
module mult_datapath #(
  parameter int N = 8
) (
  input  logic           clock,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic           add,
  input  logic           finish,
  input  logic           signed_mode,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
  output logic           b_zero,
  output logic           b_lsb,
  output logic [2*N-1:0] p
);

  logic [2*N-1:0] a_reg;
  logic [N-1:0]   b_reg;
  logic [2*N-1:0] acc;
  logic           neg;

  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic           neg_next;

  // Signed operands are reduced to magnitudes; the most negative value maps to
  // 2^(N-1), which still fits in N unsigned bits, so no overflow case exists.
  always_comb begin
    a_mag    = (signed_mode && mcand[N-1])  ? -mcand  : mcand;
    b_mag    = (signed_mode && mplier[N-1]) ? -mplier : mplier;
    neg_next = signed_mode & (mcand[N-1] ^ mplier[N-1]);
  end

  assign b_zero = (b_reg == '0);
  assign b_lsb  = b_reg[0];

  // Load operands on start, accumulate/shift per step, publish the signed product on finish.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      neg   <= 1'b0;
      p     <= '0;
    end else if (load) begin
      a_reg <= {{N{1'b0}}, a_mag};
      b_reg <= b_mag;
      acc   <= '0;
      neg   <= neg_next;
    end else if (step) begin
      if (add) begin
        acc <= acc + a_reg;
      end
      a_reg <= a_reg << 1;
      b_reg <= b_reg >> 1;
    end else if (finish) begin
      p <= neg ? -acc : acc;
    end
  end

endmodule : mult_datapath

// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - controller and top level of the sequential multiplier
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clock,
  input  logic           rst_n,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] P
);

  mult_state_t state;

  logic load;
  logic step;
  logic add;
  logic finish;
  logic b_zero;
  logic b_lsb;

  // Datapath controls: loading only outside RUN, so start during RUN is ignored;
  // the loop ends as soon as the remaining multiplier bits are all zero.
  always_comb begin
    load   = start && (state != RUN);
    step   = (state == RUN) && !b_zero;
    add    = step && b_lsb;
    finish = (state == RUN) && b_zero;
  end

  // Controller FSM with busy/done registered alongside the state so they never overlap.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        RUN: begin
          if (b_zero) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  mult_datapath #(
    .N (N)
  ) u_datapath (
    .clock       (clock),
    .rst_n       (rst_n),
    .load        (load),
    .step        (step),
    .add         (add),
    .finish      (finish),
    .signed_mode (signed_mode),
    .mcand       (A),
    .mplier      (B),
    .b_zero      (b_zero),
    .b_lsb       (b_lsb),
    .p           (P)
  );

endmodule : seq_shift_add_multiplier
